// File: rtl/elastic_buffer_fill_monitor.sv
// Purpose: read-domain fill monitor for the PHY rx elastic buffer; requests SKP insertion when it runs low.
// Latency: write pointer -> fill_level 3 edges, read pointer -> fill_level 1 edge, warnings 1 edge after fill_level.
// Backpressure: add_req is held until skp_added (combinational drop), then a cooldown blocks new requests.
module elastic_buffer_fill_monitor #(
  parameter int BUFFER_DEPTH    = 16,
  parameter int LOW_MARK        = 4,
  parameter int HIGH_MARK       = 12,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 8,
  parameter int AW              = $clog2(BUFFER_DEPTH)
) (
  input  logic             read_clk,
  input  logic             rst_n,
  input  logic [AW:0]      gray_write_pointer,
  input  logic [AW:0]      gray_read_pointer,
  input  logic             skp_added,
  output logic             add_req,
  output logic [AW:0]      fill_level,
  output logic             low_warn,
  output logic             high_warn,
  output logic [CNT_W-1:0] skp_insert_count
);

  // Cooldown counter only needs to hold COOLDOWN_CYCLES-1.
  localparam int CDW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CDW-1:0]   CD_LOAD = CDW'(COOLDOWN_CYCLES - 1);
  localparam logic [AW:0]      LOW_L   = (AW+1)'(LOW_MARK);
  localparam logic [AW:0]      HIGH_L  = (AW+1)'(HIGH_MARK);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    REQUEST  = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t         state;
  logic [CDW-1:0] cool_cnt;
  logic [AW:0]    wr_sync1;
  logic [AW:0]    wr_sync2;
  logic [AW:0]    wr_bin;
  logic [AW:0]    rd_bin;
  logic           primed;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wr_bin = gray2bin(wr_sync2);
  assign rd_bin = gray2bin(gray_read_pointer);

  // Two-flop synchronizer on the gray write pointer; safe because only one bit moves per write.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync1 <= '0;
      wr_sync2 <= '0;
    end else begin
      wr_sync1 <= gray_write_pointer;
      wr_sync2 <= wr_sync1;
    end
  end

  // Occupancy register; the extra MSB makes the modulo subtraction handle pointer wrap.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_level <= '0;
    end else begin
      fill_level <= wr_bin - rd_bin;
    end
  end

  // Primed latch and level warnings, all derived from the registered occupancy.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      primed    <= 1'b0;
      low_warn  <= 1'b0;
      high_warn <= 1'b0;
    end else begin
      primed    <= primed | (fill_level >= LOW_L);
      low_warn  <= primed & (fill_level < LOW_L);
      high_warn <= (fill_level >= HIGH_L);
    end
  end

  // Insertion FSM: one request per low episode, exactly one symbol per handshake, then cooldown.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= MONITOR;
      cool_cnt         <= '0;
      skp_insert_count <= '0;
    end else begin
      case (state)
        MONITOR: begin
          // An empty buffer already stalls the reader, so it never needs an insertion.
          if (primed && (fill_level != '0) && (fill_level < LOW_L)) begin
            state <= REQUEST;
          end
        end
        REQUEST: begin
          // A completed insertion takes priority over a simultaneous drift recovery.
          if (skp_added) begin
            state    <= COOLDOWN;
            cool_cnt <= CD_LOAD;
            if (skp_insert_count != CNT_MAX) begin
              skp_insert_count <= skp_insert_count + CNT_W'(1);
            end
          end else if (fill_level >= LOW_L) begin
            state <= MONITOR;
          end
        end
        COOLDOWN: begin
          // Leaving on the decrement to zero gives COOLDOWN_CYCLES+1 cycles between insertions.
          if (cool_cnt <= CDW'(1)) begin
            state    <= MONITOR;
            cool_cnt <= '0;
          end else begin
            cool_cnt <= cool_cnt - CDW'(1);
          end
        end
        default: begin
          state    <= MONITOR;
          cool_cnt <= '0;
        end
      endcase
    end
  end

  // Request drops in the very cycle the reader stalls on the SKP so only one symbol is inserted.
  assign add_req = (state == REQUEST) && !skp_added;

endmodule

// File: tb/tb_elastic_buffer_fill_monitor.sv
// Purpose: directed plus random bench for elastic_buffer_fill_monitor against a pointer-history model.
// Latency: expectations derived from pointer history (write sampled 2 edges back, read at the edge).
// Backpressure: skp_added pulses are driven only when add_req is observed high.
module tb_elastic_buffer_fill_monitor;

  logic       read_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] gray_write_pointer;
  logic [4:0] gray_read_pointer;
  logic       skp_added;
  logic       add_req;
  logic [4:0] fill_level;
  logic       low_warn;
  logic       high_warn;
  logic [7:0] skp_insert_count;

  elastic_buffer_fill_monitor dut (
    .read_clk           (read_clk),
    .rst_n              (rst_n),
    .gray_write_pointer (gray_write_pointer),
    .gray_read_pointer  (gray_read_pointer),
    .skp_added          (skp_added),
    .add_req            (add_req),
    .fill_level         (fill_level),
    .low_warn           (low_warn),
    .high_warn          (high_warn),
    .skp_insert_count   (skp_insert_count)
  );

  always #5 read_clk = ~read_clk;

  int errors = 0;
  int checks = 0;

  // Model state: binary pointers driven, and the pointer values present at each edge since reset.
  int wr_b = 0;
  int rd_b = 0;
  int wh[$];
  int rh[$];
  int prev_fill = 0;
  bit primed_m = 1'b0;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ptr(input int w, input int r);
    wr_b = w & 31;
    rd_b = r & 31;
    gray_write_pointer = to_gray(wr_b);
    gray_read_pointer  = to_gray(rd_b);
  endtask

  // One clock edge, then compare fill_level and both warnings with the history model.
  task automatic tick;
    int k;
    int w2;
    int ef;
    @(posedge read_clk);
    #1;
    wh.push_back(wr_b);
    rh.push_back(rd_b);
    k  = wh.size();
    w2 = (k >= 3) ? wh[k-3] : 0;
    ef = (w2 - rh[k-1]) & 31;
    chk("fill_level", 32'(fill_level), 32'(ef));
    chk("high_warn", 32'(high_warn), 32'(prev_fill >= 12));
    chk("low_warn", 32'(low_warn), 32'(primed_m && prev_fill < 4));
    if (prev_fill >= 4) primed_m = 1'b1;
    prev_fill = ef;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    skp_added = 1'b0;
    #1;
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_add_req", 32'(add_req), 32'd0);
    chk("rst_low_warn", 32'(low_warn), 32'd0);
    chk("rst_high_warn", 32'(high_warn), 32'd0);
    chk("rst_count", 32'(skp_insert_count), 32'd0);
    set_ptr(0, 0);
    repeat (2) @(posedge read_clk);
    #1;
    rst_n = 1'b1;
    wh.delete();
    rh.delete();
    prev_fill = 0;
    primed_m = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (add_req !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    chk("wait_add_req", 32'(add_req), 32'd1);
  endtask

  task automatic pulse_skp;
    skp_added = 1'b1;
    #1;
    chk("add_req_drop", 32'(add_req), 32'd0);
    tick;
    skp_added = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_exp[4];
    int wp;
    lat_exp = '{1, 2, 3, 4};
    set_ptr(0, 0);
    skp_added = 1'b0;
    #3;
    do_reset;

    // Latency/fill: write steps 0->1->2->3->4 one per cycle, read held at 0.
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) set_ptr(i, 0);
      tick;
      if (i >= 3) chk("lat_fill", 32'(fill_level), 32'(lat_exp[i-3]));
    end

    // Insertion handshake at level 3 after priming.
    set_ptr(4, 1);
    tick;
    chk("req_before", 32'(add_req), 32'd0);
    tick;
    chk("req_rise", 32'(add_req), 32'd1);
    chk("primed_low_warn", 32'(low_warn), 32'd1);
    pulse_skp;
    chk("count_one", 32'(skp_insert_count), 32'd1);
    chk("cool_0", 32'(add_req), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("cool_hold", 32'(add_req), 32'd0);
    end
    tick;
    chk("req_again", 32'(add_req), 32'd1);

    // Recovery without insertion: level back to 4 while requesting.
    set_ptr(4, 0);
    tick;
    chk("recov_still", 32'(add_req), 32'd1);
    tick;
    chk("recov_drop", 32'(add_req), 32'd0);
    repeat (3) begin
      tick;
      chk("recov_idle", 32'(add_req), 32'd0);
    end
    chk("recov_count", 32'(skp_insert_count), 32'd1);

    // Empty buffer after priming never requests.
    set_ptr(4, 4);
    repeat (12) begin
      tick;
      chk("empty_no_req", 32'(add_req), 32'd0);
    end

    // Asynchronous reset mid-REQUEST.
    set_ptr(4, 1);
    wait_req(10);
    do_reset;
    tick;
    chk("post_rst_req", 32'(add_req), 32'd0);

    // Level 2 before priming never requests.
    set_ptr(1, 0);
    tick;
    set_ptr(2, 0);
    repeat (12) begin
      tick;
      chk("unprimed_no_req", 32'(add_req), 32'd0);
    end

    // Wrap-around: write binary 2, read binary 30.
    do_reset;
    set_ptr(1, 30);
    tick;
    set_ptr(2, 30);
    repeat (4) tick;
    chk("wrap_fill", 32'(fill_level), 32'd4);

    // Saturation of the insertion counter.
    do_reset;
    for (int i = 1; i <= 3; i++) begin
      set_ptr(i, 0);
      tick;
    end
    set_ptr(4, 0);
    repeat (4) tick;
    set_ptr(4, 1);
    for (int i = 1; i <= 260; i++) begin
      wait_req(20);
      pulse_skp;
      chk("sat_count", 32'(skp_insert_count), 32'((i > 255) ? 255 : i));
    end

    // Random pointer walk: write-heavy then read-heavy phases.
    do_reset;
    for (int i = 0; i < 600; i++) begin
      wp = ((i % 200) < 100) ? 3 : 1;
      if (int'($urandom_range(3)) < wp && ((wr_b - rd_b) & 31) < 16) wr_b = wr_b + 1;
      if (int'($urandom_range(3)) >= wp && ((wr_b - rd_b) & 31) > 0) rd_b = rd_b + 1;
      set_ptr(wr_b, rd_b);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
